uart_task_sequencer: RTL and testbench

- Parametrised successor to the FPGA_A task-selection state machine.
- Drives the full command cycle over a byte-stream UART interface:
  - prints the "Enter opcode:" prompt;
  - receives an ASCII opcode and two DATA_W operands;
  - dispatches to an external arithmetic unit and waits for completion, with a timeout;
  - transmits the result back and reports done/error.
- Sits between the UART FIFOs and the operation datapath (add/sub/mul/I2C).

---
 rtl/uart_task_sequencer.sv | 343 ++++++++++++++++++++++++++++++++++
 tb/tb_uart_task_sequencer.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/uart_task_sequencer.sv
// Command sequencer between the UART byte FIFOs and an external arithmetic unit.
// Define UART_TASK_SEQ_ECHO_EN to echo every byte received in GET_OP/GET_A/GET_B.
module uart_task_sequencer #(
    parameter int DATA_W         = 32,
    parameter int NUM_OPS        = 4,
    parameter int TIMEOUT_CYCLES = 1024,
    localparam int OP_W          = (NUM_OPS > 1) ? $clog2(NUM_OPS) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              rx_ready,
    output logic [7:0]        tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              op_start,
    output logic [OP_W-1:0]   op_sel,
    output logic [DATA_W-1:0] op_a,
    output logic [DATA_W-1:0] op_b,
    input  logic              op_done,
    input  logic [DATA_W-1:0] op_result,
    output logic              busy,
    output logic              done,
    output logic [1:0]        err_code
);

    localparam int BYTES = DATA_W / 8;
    localparam int IDX_N = (BYTES > 13) ? BYTES : 13;
    localparam int IDX_W = $clog2(IDX_N);
    localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [7:0] OP_LO  = 8'h30;
    localparam logic [7:0] OP_HI  = 8'(8'h30 + NUM_OPS);
    localparam logic [7:0] ERR_OP = 8'h3F;
    localparam logic [7:0] ERR_TO = 8'h21;

    typedef enum logic [3:0] {
        ST_IDLE     = 4'd0,
        ST_PROMPT   = 4'd1,
        ST_GET_OP   = 4'd2,
        ST_GET_A    = 4'd3,
        ST_GET_B    = 4'd4,
        ST_EXEC     = 4'd5,
        ST_WAIT_OP  = 4'd6,
        ST_SEND_RES = 4'd7,
        ST_ERR_TX   = 4'd8,
        ST_DONE     = 4'd9,
        ST_ECHO     = 4'd10
    } state_t;

    function automatic logic [7:0] prompt_byte(input logic [IDX_W-1:0] i);
        case (int'(i))
            0:       prompt_byte = 8'h45;
            1:       prompt_byte = 8'h6E;
            2:       prompt_byte = 8'h74;
            3:       prompt_byte = 8'h65;
            4:       prompt_byte = 8'h72;
            5:       prompt_byte = 8'h20;
            6:       prompt_byte = 8'h6F;
            7:       prompt_byte = 8'h70;
            8:       prompt_byte = 8'h63;
            9:       prompt_byte = 8'h6F;
            10:      prompt_byte = 8'h64;
            11:      prompt_byte = 8'h65;
            12:      prompt_byte = 8'h3A;
            default: prompt_byte = 8'h00;
        endcase
    endfunction

    state_t            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d;
    logic [DATA_W-1:0] res_q, res_d;
    logic              rx_ready_q, rx_ready_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              op_start_q, op_start_d;
    logic [OP_W-1:0]   op_sel_q, op_sel_d;
    logic [DATA_W-1:0] op_a_q, op_a_d;
    logic [DATA_W-1:0] op_b_q, op_b_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [1:0]        err_q, err_d;
`ifdef UART_TASK_SEQ_ECHO_EN
    state_t            ret_q, ret_d;
`endif

    logic              rx_fire_s, tx_fire_s;
    logic              acc_s, enter_s;
    state_t            acc_next_s, enter_state_s;
    logic [TMO_W-1:0]  tmo_inc_s;
    logic [DATA_W-1:0] res_shift_s;

    // Next-state and next-output computation for the whole command cycle.
    always_comb begin
        state_d       = state_q;
        idx_d         = idx_q;
        tmo_d         = tmo_q;
        res_d         = res_q;
        rx_ready_d    = rx_ready_q;
        tx_data_d     = tx_data_q;
        tx_valid_d    = tx_valid_q;
        op_start_d    = 1'b0;
        op_sel_d      = op_sel_q;
        op_a_d        = op_a_q;
        op_b_d        = op_b_q;
        busy_d        = busy_q;
        done_d        = 1'b0;
        err_d         = err_q;
`ifdef UART_TASK_SEQ_ECHO_EN
        ret_d         = ret_q;
`endif
        rx_fire_s     = rx_valid && rx_ready_q;
        tx_fire_s     = tx_valid_q && tx_ready;
        acc_s         = 1'b0;
        acc_next_s    = state_q;
        enter_s       = 1'b0;
        enter_state_s = state_q;
        tmo_inc_s     = tmo_q + 1'b1;
        res_shift_s   = res_q << 4'd8;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d    = ST_PROMPT;
                    err_d      = 2'd0;
                    busy_d     = 1'b1;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = prompt_byte('0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_PROMPT: begin
                if (tx_fire_s) begin
                    if (idx_q == IDX_W'(12)) begin
                        idx_d      = '0;
                        tx_valid_d = 1'b0;
                        rx_ready_d = 1'b1;
                        state_d    = ST_GET_OP;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        tx_data_d = prompt_byte(idx_q + 1'b1);
                    end
                end else begin
                    state_d = ST_PROMPT;
                end
            end
            ST_GET_OP: begin
                if (rx_fire_s) begin
                    acc_s = 1'b1;
                    if ((rx_data >= OP_LO) && (rx_data < OP_HI)) begin
                        op_sel_d   = OP_W'(rx_data - OP_LO);
                        acc_next_s = ST_GET_A;
                    end else begin
                        err_d      = 2'd1;
                        acc_next_s = ST_ERR_TX;
                    end
                end else begin
                    state_d = ST_GET_OP;
                end
            end
            ST_GET_A, ST_GET_B: begin
                if (rx_fire_s) begin
                    acc_s = 1'b1;
                    if (state_q == ST_GET_A) begin
                        op_a_d = (op_a_q << 4'd8) | DATA_W'(rx_data);
                    end else begin
                        op_b_d = (op_b_q << 4'd8) | DATA_W'(rx_data);
                    end
                    if (idx_q == IDX_W'(BYTES - 1)) begin
                        idx_d      = '0;
                        acc_next_s = (state_q == ST_GET_A) ? ST_GET_B : ST_EXEC;
                    end else begin
                        idx_d      = idx_q + 1'b1;
                        acc_next_s = state_q;
                    end
                end else begin
                    state_d = state_q;
                end
            end
            ST_EXEC: begin
                state_d = ST_WAIT_OP;
                tmo_d   = '0;
            end
            ST_WAIT_OP: begin
                // op_done takes priority over a timeout landing on the same edge.
                if (op_done) begin
                    res_d      = op_result;
                    idx_d      = '0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = op_result[DATA_W-1 -: 8];
                    state_d    = ST_SEND_RES;
                end else if (tmo_inc_s >= TMO_W'(TIMEOUT_CYCLES - 1)) begin
                    tmo_d      = tmo_inc_s;
                    err_d      = 2'd2;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ERR_TO;
                    state_d    = ST_ERR_TX;
                end else begin
                    tmo_d = tmo_inc_s;
                end
            end
            ST_SEND_RES: begin
                if (tx_fire_s) begin
                    if (idx_q == IDX_W'(BYTES - 1)) begin
                        tx_valid_d = 1'b0;
                        done_d     = 1'b1;
                        state_d    = ST_DONE;
                    end else begin
                        idx_d     = idx_q + 1'b1;
                        res_d     = res_shift_s;
                        tx_data_d = res_shift_s[DATA_W-1 -: 8];
                    end
                end else begin
                    state_d = ST_SEND_RES;
                end
            end
            ST_ERR_TX: begin
                if (tx_fire_s) begin
                    tx_valid_d = 1'b0;
                    done_d     = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    state_d = ST_ERR_TX;
                end
            end
            ST_DONE: begin
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
`ifdef UART_TASK_SEQ_ECHO_EN
            ST_ECHO: begin
                if (tx_fire_s) begin
                    enter_s       = 1'b1;
                    enter_state_s = ret_q;
                end else begin
                    state_d = ST_ECHO;
                end
            end
`endif
            default: begin
                state_d    = ST_IDLE;
                busy_d     = 1'b0;
                rx_ready_d = 1'b0;
                tx_valid_d = 1'b0;
            end
        endcase

        if (acc_s) begin
`ifdef UART_TASK_SEQ_ECHO_EN
            state_d    = ST_ECHO;
            ret_d      = acc_next_s;
            rx_ready_d = 1'b0;
            tx_valid_d = 1'b1;
            tx_data_d  = rx_data;
`else
            enter_s       = 1'b1;
            enter_state_s = acc_next_s;
`endif
        end else begin
            enter_s = enter_s;
        end

        // Common entry actions once a received byte has been fully handled.
        if (enter_s) begin
            state_d = enter_state_s;
            case (enter_state_s)
                ST_ERR_TX: begin
                    rx_ready_d = 1'b0;
                    tx_valid_d = 1'b1;
                    tx_data_d  = ERR_OP;
                end
                ST_EXEC: begin
                    rx_ready_d = 1'b0;
                    tx_valid_d = 1'b0;
                    op_start_d = 1'b1;
                end
                default: begin
                    rx_ready_d = 1'b1;
                    tx_valid_d = 1'b0;
                end
            endcase
        end else begin
            op_start_d = op_start_d;
        end
    end

    // State and registered-output flops.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            idx_q      <= '0;
            tmo_q      <= '0;
            res_q      <= '0;
            rx_ready_q <= 1'b0;
            tx_data_q  <= 8'h00;
            tx_valid_q <= 1'b0;
            op_start_q <= 1'b0;
            op_sel_q   <= '0;
            op_a_q     <= '0;
            op_b_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 2'd0;
`ifdef UART_TASK_SEQ_ECHO_EN
            ret_q      <= ST_IDLE;
`endif
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            tmo_q      <= tmo_d;
            res_q      <= res_d;
            rx_ready_q <= rx_ready_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            op_start_q <= op_start_d;
            op_sel_q   <= op_sel_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
`ifdef UART_TASK_SEQ_ECHO_EN
            ret_q      <= ret_d;
`endif
        end
    end

    assign rx_ready = rx_ready_q;
    assign tx_data  = tx_data_q;
    assign tx_valid = tx_valid_q;
    assign op_start = op_start_q;
    assign op_sel   = op_sel_q;
    assign op_a     = op_a_q;
    assign op_b     = op_b_q;
    assign busy     = busy_q;
    assign done     = done_q;
    assign err_code = err_q;

endmodule

// File: tb/tb_uart_task_sequencer.sv
// Scoreboard bench for uart_task_sequencer: expected TX bytes queued at stimulus time.
module tb_uart_task_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready = 1'b1;
    logic        op_start;
    logic [1:0]  op_sel;
    logic [31:0] op_a, op_b;
    logic        op_done = 1'b0;
    logic [31:0] op_result = 32'h0;
    logic        busy, done;
    logic [1:0]  err_code;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [7:0]  exp_tx[$];
    logic [7:0]  rx_q[$];
    logic        stall_mode = 1'b0;
    logic        stall_chk = 1'b0;
    logic [7:0]  stall_data = 8'h00;
    logic [7:0]  prompt [13] = '{8'h45, 8'h6E, 8'h74, 8'h65, 8'h72, 8'h20, 8'h6F,
                                 8'h70, 8'h63, 8'h6F, 8'h64, 8'h65, 8'h3A};

    uart_task_sequencer #(.DATA_W(32), .NUM_OPS(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .start(start),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .op_start(op_start), .op_sel(op_sel), .op_a(op_a), .op_b(op_b),
        .op_done(op_done), .op_result(op_result),
        .busy(busy), .done(done), .err_code(err_code)
    );

    initial forever #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // RX FIFO model: pops on handshake, optionally gaps rx_valid.
    initial forever begin
        @(posedge clk);
        if (rx_valid && rx_ready && rx_q.size() > 0) void'(rx_q.pop_front());
        #1;
        if (rx_q.size() > 0 && (!stall_mode || $urandom_range(0, 1) == 1)) begin
            rx_valid = 1'b1;
            rx_data  = rx_q[0];
        end else begin
            rx_valid = 1'b0;
        end
    end

    // TX FIFO readiness: constant or toggling every cycle.
    initial forever begin
        @(posedge clk);
        #1;
        tx_ready = stall_mode ? ~tx_ready : 1'b1;
    end

    // TX monitor: compares accepted bytes against the scoreboard and checks hold-while-stalled.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            stall_chk = 1'b0;
        end else begin
            if (stall_chk) begin
                check("tx_hold_valid", tx_valid, 1);
                check("tx_hold_data", tx_data, stall_data);
            end
            if (tx_valid && tx_ready) begin
                check("tx_expected_avail", exp_tx.size() > 0, 1);
                if (exp_tx.size() > 0) check("tx_byte", tx_data, exp_tx.pop_front());
            end
            stall_chk  = tx_valid && !tx_ready;
            stall_data = tx_data;
        end
    end

    // kind: 0 = result, 1 = bad opcode, 2 = timeout
    task automatic do_cmd(input logic [7:0] opc, input logic [31:0] a, input logic [31:0] b,
                          input int kind, input logic [31:0] res, input int dly);
        int cyc, n_start, s_cyc, cd, err_cyc, rdy_cyc;
        for (int i = 0; i < 13; i++) exp_tx.push_back(prompt[i]);
        rx_q.push_back(opc);
        if (kind != 1) begin
            for (int i = 3; i >= 0; i--) rx_q.push_back(a[i*8 +: 8]);
            for (int i = 3; i >= 0; i--) rx_q.push_back(b[i*8 +: 8]);
        end
        if (kind == 0) begin
            for (int i = 3; i >= 0; i--) exp_tx.push_back(res[i*8 +: 8]);
        end else begin
            exp_tx.push_back((kind == 1) ? 8'h3F : 8'h21);
        end
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check("busy_after_start", busy, 1);
        cyc = 0; n_start = 0; s_cyc = -1; cd = -1; err_cyc = -1; rdy_cyc = -1;
        while (!done && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            op_done = 1'b0;
            if (rx_ready && rdy_cyc < 0) rdy_cyc = cyc;
            if (tx_valid && tx_data == 8'h21 && err_cyc < 0 && kind == 2) err_cyc = cyc;
            if (op_start) begin
                n_start++;
                s_cyc = cyc;
                check("op_sel", op_sel, opc - 8'h30);
                check("op_a", op_a, a);
                check("op_b", op_b, b);
                if (kind == 0) cd = dly;
            end else if (cd > 0) begin
                cd--;
                if (cd == 0) begin
                    op_done   = 1'b1;
                    op_result = res;
                end
            end
        end
        op_done = 1'b0;
        check("done_seen", done, 1);
        check("err_code", err_code, (kind == 0) ? 0 : kind);
        check("op_start_count", n_start, (kind == 1) ? 0 : 1);
        if (kind == 2) check("timeout_latency", err_cyc - s_cyc, 16);
        if (!stall_mode) check("prompt_cycles", rdy_cyc, 13);
        check("tx_all_sent", exp_tx.size(), 0);
        check("rx_all_used", rx_q.size(), 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("busy_idle", busy, 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_tx_valid", tx_valid, 0);
        check("rst_rx_ready", rx_ready, 0);
        check("rst_done", done, 0);
        check("rst_err", err_code, 0);
        check("rst_op_start", op_start, 0);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        do_cmd(8'h31, 32'h5, 32'h3, 0, 32'h2, 10);
        do_cmd(8'h37, 32'h0, 32'h0, 1, 32'h0, 0);
        do_cmd(8'h2F, 32'h0, 32'h0, 1, 32'h0, 0);
        do_cmd(8'h33, 32'hDEADBEEF, 32'h12345678, 0, 32'hCAFEF00D, 15);
        do_cmd(8'h30, 32'h11223344, 32'h55667788, 2, 32'h0, 0);
        do_cmd(8'h34, 32'h0, 32'h0, 1, 32'h0, 0);

        stall_mode = 1'b1;
        do_cmd(8'h32, 32'hA5A55A5A, 32'h0F0F0F0F, 0, 32'h89ABCDEF, 5);
        do_cmd(8'h39, 32'h0, 32'h0, 1, 32'h0, 0);
        stall_mode = 1'b0;

        // Reset in the middle of operand A.
        for (int i = 0; i < 13; i++) exp_tx.push_back(prompt[i]);
        rx_q.push_back(8'h32);
        rx_q.push_back(8'hAB);
        rx_q.push_back(8'hCD);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        cyc = 0;
        while (rx_q.size() > 0 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        check("pre_reset_rx_ready", rx_ready, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_rx_ready", rx_ready, 0);
        check("mid_rst_tx_valid", tx_valid, 0);
        check("mid_rst_op_a", op_a, 0);
        check("mid_rst_op_sel", op_sel, 0);
        check("mid_rst_done", done, 0);
        exp_tx.delete();
        rx_q.delete();
        repeat (2) @(negedge clk);
        reset = 1'b0;
        cyc = 0;
        repeat (4) begin
            @(negedge clk);
            cyc += done + tx_valid;
        end
        check("post_rst_quiet", cyc, 0);
        do_cmd(8'h31, 32'h00000100, 32'h00000020, 0, 32'h000000E0, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
